// File: rtl/cache_pkg.sv
// Shared cache types and line-layout constants.
// Used by the refill controller and the cache array.
package cache_pkg;

    localparam int WORD_SIZE      = 32;
    localparam int INDEX_BITS     = 5;
    localparam int BLOCK_OFFSET   = 6;
    localparam int TAG_BITS       = 32 - INDEX_BITS - BLOCK_OFFSET;
    localparam int WORDS_PER_LINE = 2 ** (BLOCK_OFFSET - 2);
    localparam int CNT_BITS       = BLOCK_OFFSET - 2;
    localparam int LINE_LENGTH    = TAG_BITS + WORDS_PER_LINE * WORD_SIZE + 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WRITE,
        SETTLE
    } state_t;

    function automatic int word_lsb(input int k);
        return k * WORD_SIZE + 1;
    endfunction

endpackage

// File: rtl/cache_refill_ctrl_line_assembler.sv
// Word buffer for a refill: collects returned words into a packed line
// {tag, word[15..0], valid}; the packed register is the line output.
module line_assembler
    import cache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic [CNT_BITS-1:0]    wr_idx,
    input  logic [WORD_SIZE-1:0]   wr_data,
    input  logic                   last,
    input  logic [TAG_BITS-1:0]    tag_in,
    output logic [LINE_LENGTH-1:0] line
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line <= '0;
        end else if (clear) begin
            line <= '0;
            line[LINE_LENGTH-1 -: TAG_BITS] <= tag_in;
        end else if (wr_en) begin
            line[word_lsb(int'(wr_idx)) +: WORD_SIZE] <= wr_data;
            // valid goes up only once the final word is in place
            if (last) begin
                line[0] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache miss refill: fetches one line word by word over a req/ack port,
// writes the assembled line once, then holds busy one settle cycle.
module cache_refill_ctrl
    import cache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   miss,
    input  logic [31:0]            miss_addr,
    output logic                   busy,
    output logic                   mem_req,
    output logic [31:0]            mem_addr,
    input  logic                   mem_ack,
    input  logic [WORD_SIZE-1:0]   mem_rdata,
    output logic [31:0]            line_addr,
    output logic [LINE_LENGTH-1:0] new_cache_line,
    output logic                   full_line_wr
);

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(WORDS_PER_LINE - 1);

    state_t              state, state_n;
    logic [CNT_BITS-1:0] cnt, cnt_n;
    logic                busy_n;
    logic                mem_req_n;
    logic [31:0]         mem_addr_n;
    logic [31:0]         line_addr_n;
    logic                full_line_wr_n;
    logic                clear;
    logic                wr_en;
    logic                last;

    assign last = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            busy         <= 1'b0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            line_addr    <= '0;
            full_line_wr <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            busy         <= busy_n;
            mem_req      <= mem_req_n;
            mem_addr     <= mem_addr_n;
            line_addr    <= line_addr_n;
            full_line_wr <= full_line_wr_n;
        end
    end

    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        busy_n         = busy;
        mem_req_n      = mem_req;
        mem_addr_n     = mem_addr;
        line_addr_n    = line_addr;
        full_line_wr_n = 1'b0;
        clear          = 1'b0;
        wr_en          = 1'b0;
        unique case (state)
            IDLE: begin
                if (miss) begin
                    line_addr_n = {miss_addr[31:BLOCK_OFFSET], {BLOCK_OFFSET{1'b0}}};
                    cnt_n       = '0;
                    busy_n      = 1'b1;
                    mem_req_n   = 1'b1;
                    mem_addr_n  = line_addr_n;
                    clear       = 1'b1;
                    state_n     = FETCH;
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    wr_en = 1'b1;
                    if (last) begin
                        mem_req_n      = 1'b0;
                        full_line_wr_n = 1'b1;
                        state_n        = WRITE;
                    end else begin
                        // counter field replaces the offset bits, so no carry into the index
                        cnt_n      = cnt + 1'b1;
                        mem_addr_n = {line_addr[31:BLOCK_OFFSET], cnt_n, 2'b00};
                    end
                end
            end
            WRITE: begin
                state_n = SETTLE;
            end
            SETTLE: begin
                busy_n  = 1'b0;
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    line_assembler u_asm (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .wr_en   (wr_en),
        .wr_idx  (cnt),
        .wr_data (mem_rdata),
        .last    (last),
        .tag_in  (miss_addr[31 -: TAG_BITS]),
        .line    (new_cache_line)
    );

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl with a req/ack memory model.
module tb_cache_refill_ctrl;
    import cache_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   miss;
    logic [31:0]            miss_addr;
    logic                   busy;
    logic                   mem_req;
    logic [31:0]            mem_addr;
    logic                   mem_ack;
    logic [WORD_SIZE-1:0]   mem_rdata;
    logic [31:0]            line_addr;
    logic [LINE_LENGTH-1:0] new_cache_line;
    logic                   full_line_wr;

    int checks = 0;
    int errors = 0;
    int strobes = 0;

    logic [31:0]            addr_q[$];
    logic [LINE_LENGTH-1:0] line_q[$];
    logic [LINE_LENGTH-1:0] last_line;

    always #5 clk = ~clk;

    cache_refill_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .miss           (miss),
        .miss_addr      (miss_addr),
        .busy           (busy),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .line_addr      (line_addr),
        .new_cache_line (new_cache_line),
        .full_line_wr   (full_line_wr)
    );

    always @(negedge clk) begin
        if (full_line_wr) strobes++;
    end

    task automatic check(input string tag,
                         input logic [LINE_LENGTH-1:0] got,
                         input logic [LINE_LENGTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic push_expect(input logic [31:0] a);
        logic [31:0]            base;
        logic [LINE_LENGTH-1:0] e;
        base = a & 32'hFFFF_FFC0;
        e = '0;
        e[0] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            addr_q.push_back(base + 32'(4 * k));
            e[k * 32 + 1 +: 32] = 32'hA000_0000 + 32'(k);
        end
        e[LINE_LENGTH-1 -: 21] = a[31:11];
        line_q.push_back(e);
    endtask

    task automatic refill(input logic [31:0] a, input int dly,
                          input int abort_w, input int miss_w,
                          input bit spur);
        int                     cyc;
        logic [31:0]            base;
        logic [31:0]            ea;
        logic [LINE_LENGTH-1:0] el;
        int                     s0;
        base = a & 32'hFFFF_FFC0;
        s0 = strobes;
        push_expect(a);
        miss = 1'b1;
        miss_addr = a;
        cyc = 0;
        @(negedge clk);
        cyc++;
        miss = 1'b0;
        miss_addr = 32'h5555_5555;
        check("busy_rise", busy, 1);
        check("line_addr", line_addr, base);
        for (int k = 0; k < 16; k++) begin
            if (k == miss_w) begin
                miss = 1'b1;
                miss_addr = 32'hFFFF_FFC0;
            end
            for (int w = 0; w < dly; w++) begin
                mem_ack = 1'b0;
                check("req_wait", mem_req, 1);
                check("addr_wait", mem_addr, addr_q[0]);
                @(negedge clk);
                cyc++;
            end
            ea = addr_q.pop_front();
            check("req", mem_req, 1);
            check("mem_addr", mem_addr, ea);
            check("busy_fetch", busy, 1);
            mem_ack = 1'b1;
            mem_rdata = 32'hA000_0000 + 32'(k);
            @(negedge clk);
            cyc++;
            mem_ack = 1'b0;
            miss = 1'b0;
            if (k == abort_w) begin
                rst = 1'b1;
                #1;
                check("rst_busy", busy, 0);
                check("rst_req", mem_req, 0);
                check("rst_maddr", mem_addr, 0);
                check("rst_laddr", line_addr, 0);
                check("rst_line", new_cache_line, 0);
                check("rst_wr", full_line_wr, 0);
                @(negedge clk);
                rst = 1'b0;
                check("abort_strobes", strobes, s0);
                addr_q.delete();
                line_q.delete();
                last_line = '0;
                return;
            end
        end
        el = line_q.pop_front();
        check("wr_strobe", full_line_wr, 1);
        check("req_low", mem_req, 0);
        check("line", new_cache_line, el);
        check("line_addr_end", line_addr, base);
        last_line = el;
        @(negedge clk);
        cyc++;
        check("wr_once", full_line_wr, 0);
        check("busy_settle", busy, 1);
        if (spur) begin
            mem_ack = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        cyc++;
        mem_ack = 1'b0;
        check("busy_fall", busy, 0);
        check("latency", cyc, 1 + 16 * (dly + 1) + 2);
        check("strobe_cnt", strobes, s0 + 1);
        check("line_hold", new_cache_line, last_line);
    endtask

    initial begin
        int s0;
        rst = 1'b1;
        miss = 1'b0;
        miss_addr = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        last_line = '0;
        @(negedge clk);
        @(negedge clk);
        check("r_busy", busy, 0);
        check("r_req", mem_req, 0);
        check("r_maddr", mem_addr, 0);
        check("r_laddr", line_addr, 0);
        check("r_line", new_cache_line, 0);
        check("r_wr", full_line_wr, 0);
        rst = 1'b0;
        @(negedge clk);

        refill(32'h0000_1234, 0, -1, -1, 1'b0);
        refill(32'h0000_1234, 3, -1, -1, 1'b0);
        refill(32'h0000_1234, 0, -1, 5, 1'b0);
        refill(32'h0000_1234, 0, 9, -1, 1'b0);
        refill(32'h0000_1234, 0, -1, -1, 1'b0);
        refill(32'hFFFF_FFFC, 0, -1, -1, 1'b1);

        s0 = strobes;
        for (int i = 0; i < 3; i++) begin
            mem_ack = 1'b1;
            mem_rdata = 32'h1234_5678;
            @(negedge clk);
            check("idle_ack_busy", busy, 0);
            check("idle_ack_req", mem_req, 0);
        end
        mem_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_line", new_cache_line, last_line);
        check("idle_ack_wr", strobes, s0);
        refill(32'h0000_0040, 1, -1, -1, 1'b0);
        check("q_empty", addr_q.size() + line_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
